operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Initiator side of the register file's two read ports and single write port.
- Accepts decoded instructions from decode and drives the regfile read addresses.
- Captures operands, bypassing same-cycle writebacks, and hands them to execute over valid/ready.
- A 32-entry scoreboard stalls issue on RAW/WAW hazards against in-flight writes; writeback results are forwarded to the regfile write port.

Parameters:
ADDR_W, 5, register address width (32 architectural registers)
DATA_W, 32, register data width

Ports:
clk  in  1  clock; regfile reads on negedge, all state here updates on posedge
reset  in  1  reset, synchronous, active-high
id_valid  in  1  decode has an instruction
id_ready  out  1  fetch can accept an instruction
id_rs1  in  ADDR_W  source register 1
id_rs2  in  ADDR_W  source register 2
id_rd  in  ADDR_W  destination register
id_rd_wen  in  1  instruction writes id_rd
flush  in  1  discard the instruction currently held
rf_rd_addr_1  out  ADDR_W  regfile read port 1 address
rf_rd_data_1  in  DATA_W  regfile read port 1 data (negedge-registered)
rf_rd_addr_2  out  ADDR_W  regfile read port 2 address
rf_rd_data_2  in  DATA_W  regfile read port 2 data
wb_enable  in  1  writeback valid this cycle
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback value
rf_wr_enable  out  1  to regfile; equals wb_enable
rf_wr_addr  out  ADDR_W  to regfile; equals wb_addr
rf_wr_data  out  DATA_W  to regfile; equals wb_data
ex_valid  out  1  operands valid for execute
ex_ready  in  1  execute accepts
ex_rs1_data  out  DATA_W  operand 1
ex_rs2_data  out  DATA_W  operand 2
ex_rd  out  ADDR_W  destination, passed through
ex_rd_wen  out  1  destination write enable, passed through

Behaviour:
- Reset: state IDLE; busy[31:0]=0; latched rs1/rs2/rd/rd_wen=0; ex_valid=0; ex_rs1_data=ex_rs2_data=0; ex_rd=0; ex_rd_wen=0; id_ready forced 0 while reset=1. Reset mid-operation drops everything and does not wait for outstanding writebacks.
- rf_wr_* are combinational pass-throughs of wb_*. The regfile ignores address 0.
- rf_rd_addr_1/2 = latched rs1/rs2 in every state. The regfile captures at the negedge, so rf_rd_data is valid at the next posedge.
- FSM IDLE: id_ready=1. On id_valid&&id_ready, latch rs1/rs2/rd/rd_wen and go to READ.
- FSM READ: hazard = any of the following is true, where "busy" means busy[r] && r!=0 && !(wb_enable && wb_addr==r):
  - rs1 busy;
  - rs2 busy;
  - rd_wen && rd busy.
- If hazard, stay in READ (stall; the addresses stay driven).
- Else, at the posedge:
  - operand = 0 if rs==0; wb_data if wb_enable && wb_addr==rs; otherwise rf_rd_data.
  - Load ex_* registers and set ex_valid=1.
  - If rd_wen && rd!=0, set busy[rd].
  - Go to HOLD.
- Bypass is needed because a posedge write lands after the negedge read of the same cycle.
- FSM HOLD: ex_valid=1 and outputs stable until ex_valid&&ex_ready. Then ex_valid=0 and go to IDLE. Minimum issue interval is 3 cycles; latency from id handshake to ex_valid is 1 cycle when there is no hazard.
- Scoreboard: wb_enable && wb_addr!=0 clears busy[wb_addr]. If a set and a clear hit the same register in the same cycle, the set wins. busy[0] is always 0.
- flush (priority below reset, above everything else):
  - In READ: go to IDLE; no scoreboard change.
  - In HOLD: ex_valid=0, go to IDLE, and clear busy[ex_rd] if ex_rd_wen, so the dropped instruction cannot deadlock later readers.
  - In IDLE: no effect, and the same-cycle id handshake is suppressed.
- ex_rd_wen with rd==0 issues normally and sets no busy bit.

Test Plan:
- Reset, preload regfile x5=0x11, x6=0x22; issue rs1=5 rs2=6 rd=7 wen, ex_ready=1 -> ex_valid 1 cycle after accept, ex_rs1_data=0x11, ex_rs2_data=0x22, busy[7]=1.
- Issue rs1=0 rs2=0 -> both operands 0 regardless of rf_rd_data.
- RAW: busy[7] set; issue rs1=7; hold wb off for 3 cycles, then wb_enable addr=7 data=0xDEAD -> stays in READ 3 cycles; capture in the wb cycle with ex_rs1_data=0xDEAD (bypass); busy[7] cleared.
- WAW: rd=9 busy, issue rd=9 -> stall until wb addr=9; busy[9] stays 1 afterwards (set wins).
- ex_ready held 0 for 4 cycles in HOLD -> ex_* stable, id_ready=0; release -> IDLE, id_ready=1.
- flush in HOLD with ex_rd=4 wen -> ex_valid=0 next cycle, busy[4]=0. Assert reset during READ -> IDLE with all busy bits 0.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: regfile read/write initiator with RAW/WAW scoreboard.
// Accepts decode, reads operands, bypasses writeback, issues to execute.
//
// Ports:
//   clk, reset                   sync active-high reset
//   id_*                         decode handshake and register fields
//   flush                        drop the held instruction
//   rf_rd_addr_*/rf_rd_data_*    two regfile read ports (negedge read)
//   wb_*                         writeback in; rf_wr_* mirrors it out
//   ex_*                         operands to execute over valid/ready
module operand_fetch #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_wen,
  input  logic              flush,
  output logic [ADDR_W-1:0] rf_rd_addr_1,
  input  logic [DATA_W-1:0] rf_rd_data_1,
  output logic [ADDR_W-1:0] rf_rd_addr_2,
  input  logic [DATA_W-1:0] rf_rd_data_2,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_wr_enable,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_rd_wen
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              rd_wen_q;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_rs1_q, ex_rs2_q;
  logic [ADDR_W-1:0] ex_rd_q;
  logic              ex_rd_wen_q;

  logic              accept;
  logic              issue;
  logic              hazard;
  logic [DATA_W-1:0] op1, op2;

  assign rf_wr_enable = wb_enable;
  assign rf_wr_addr   = wb_addr;
  assign rf_wr_data   = wb_data;

  assign rf_rd_addr_1 = rs1_q;
  assign rf_rd_addr_2 = rs2_q;

  assign ex_valid    = ex_valid_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rd_wen   = ex_rd_wen_q;

  assign id_ready = (state_q == IDLE) && !reset;
  assign accept   = id_valid && id_ready && !flush;

  // A writeback landing this cycle already frees its register.
  function automatic logic pending(
    input logic [ADDR_W-1:0] r
  );
    return busy_q[r] && (r != '0) &&
           !(wb_enable && wb_addr == r);
  endfunction

  // The regfile write lands after this cycle's negedge read,
  // so a same-cycle writeback must be bypassed.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] rs,
    input logic [DATA_W-1:0] rd_data
  );
    logic [DATA_W-1:0] o;
    o = rd_data;
    priority case (1'b1)
      (rs == '0):                   o = '0;
      (wb_enable && wb_addr == rs): o = wb_data;
      default:                      o = rd_data;
    endcase
    return o;
  endfunction

  assign hazard = pending(rs1_q) || pending(rs2_q) ||
                  (rd_wen_q && pending(rd_q));

  assign op1 = fwd(rs1_q, rf_rd_data_1);
  assign op2 = fwd(rs2_q, rf_rd_data_2);

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    ex_valid_d = ex_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = READ;
      end
      READ: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!hazard) begin
          issue      = 1'b1;
          ex_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (flush || ex_ready) begin
          ex_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clears first, then the issue set so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (wb_enable && wb_addr != '0)
      busy_d[wb_addr] = 1'b0;
    if (state_q == HOLD && flush && ex_rd_wen_q)
      busy_d[ex_rd_q] = 1'b0;
    if (issue && rd_wen_q && rd_q != '0)
      busy_d[rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rd_wen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      if (accept) begin
        rs1_q    <= id_rs1;
        rs2_q    <= id_rs2;
        rd_q     <= id_rd;
        rd_wen_q <= id_rd_wen;
      end
      if (issue) begin
        ex_rs1_q    <= op1;
        ex_rs2_q    <= op2;
        ex_rd_q     <= rd_q;
        ex_rd_wen_q <= rd_wen_q;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench with regfile model
// and an expected-issue queue for operand_fetch.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rd_wen;
  logic        flush;
  logic [4:0]  rf_rd_addr_1, rf_rd_addr_2;
  logic [31:0] rf_rd_data_1, rf_rd_data_2;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   total;
  int   bad;

  logic [31:0] rf [32];

  operand_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_rd_wen    (id_rd_wen),
    .flush        (flush),
    .rf_rd_addr_1 (rf_rd_addr_1),
    .rf_rd_data_1 (rf_rd_data_1),
    .rf_rd_addr_2 (rf_rd_addr_2),
    .rf_rd_data_2 (rf_rd_data_2),
    .wb_enable    (wb_enable),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_rd        (ex_rd),
    .ex_rd_wen    (ex_rd_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_wr_enable && rf_wr_addr != 5'd0)
      rf[rf_wr_addr] <= rf_wr_data;

  always @(negedge clk) begin
    rf_rd_data_1 <= rf[rf_rd_addr_1];
    rf_rd_data_2 <= rf[rf_rd_addr_2];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag);
    if (q.size() == 0) begin
      chk({tag, "_q"}, 64'd1, 64'd0);
    end else begin
      held = q.pop_front();
      chk({tag, "_v"},   64'(ex_valid),    64'd1);
      chk({tag, "_d1"},  64'(ex_rs1_data), 64'(held.d1));
      chk({tag, "_d2"},  64'(ex_rs2_data), 64'(held.d2));
      chk({tag, "_rd"},  64'(ex_rd),       64'(held.rd));
      chk({tag, "_wen"}, 64'(ex_rd_wen),   64'(held.wen));
    end
  endtask

  task automatic issue(
    input logic [4:0] r1,
    input logic [4:0] r2,
    input logic [4:0] rd,
    input logic       wen
  );
    id_valid  = 1'b1;
    id_rs1    = r1;
    id_rs2    = r2;
    id_rd     = rd;
    id_rd_wen = wen;
    step();
    id_valid  = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_enable = 1'b1;
    wb_addr   = a;
    wb_data   = d;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    id_valid = 1'b0;
    id_rs1 = '0;
    id_rs2 = '0;
    id_rd = '0;
    id_rd_wen = 1'b0;
    flush = 1'b0;
    wb_enable = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    ex_ready = 1'b1;

    step();
    chk("rst_idrdy", 64'(id_ready), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_exv",  64'(ex_valid),    64'd0);
    chk("rst_d1",   64'(ex_rs1_data), 64'd0);
    chk("rst_rd",   64'(ex_rd),       64'd0);
    chk("rst_busy", 64'(dut.busy_q),  64'd0);
    chk("rst_rdy",  64'(id_ready),    64'd1);

    // preload x5/x6 through the writeback port
    wb(5'd5, 32'h11);
    chk("wr_pass_en",   64'(rf_wr_enable), 64'd1);
    chk("wr_pass_data", 64'(rf_wr_data),   64'h11);
    step();
    wb(5'd6, 32'h22);
    step();
    wb_enable = 1'b0;

    // basic issue, one-cycle latency
    q.push_back('{32'h11, 32'h22, 5'd7, 1'b1});
    issue(5'd5, 5'd6, 5'd7, 1'b1);
    chk("t1_read_v", 64'(ex_valid), 64'd0);
    chk("t1_read_r", 64'(id_ready), 64'd0);
    step();
    chk_ex("t1");
    chk("t1_busy7", 64'(dut.busy_q[7]), 64'd1);
    step();
    chk("t1_done_v", 64'(ex_valid), 64'd0);
    chk("t1_done_r", 64'(id_ready), 64'd1);

    // x0 operands read as zero; rd=0 sets no busy bit
    q.push_back('{32'h0, 32'h0, 5'd0, 1'b1});
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    step();
    chk_ex("t2");
    chk("t2_busy", 64'(dut.busy_q), 64'h80);
    step();

    // RAW on x7: three stall cycles then bypassed wb
    q.push_back('{32'hDEAD, 32'h11, 5'd10, 1'b0});
    issue(5'd7, 5'd5, 5'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall", 64'(ex_valid), 64'd0);
    end
    wb(5'd7, 32'hDEAD);
    step();
    wb_enable = 1'b0;
    chk_ex("t3");
    chk("t3_busy7", 64'(dut.busy_q[7]), 64'd0);
    step();

    // WAW on x9: set wins over same-cycle clear
    q.push_back('{32'h11, 32'h22, 5'd9, 1'b1});
    issue(5'd5, 5'd6, 5'd9, 1'b1);
    step();
    chk_ex("t4a");
    step();
    q.push_back('{32'h22, 32'h11, 5'd9, 1'b1});
    issue(5'd6, 5'd5, 5'd9, 1'b1);
    step();
    chk("t4_stall", 64'(ex_valid), 64'd0);
    wb(5'd9, 32'h99);
    step();
    wb_enable = 1'b0;
    chk_ex("t4b");
    chk("t4_busy9", 64'(dut.busy_q[9]), 64'd1);
    step();
    wb(5'd9, 32'h99);
    step();
    wb_enable = 1'b0;

    // backpressure in HOLD
    ex_ready = 1'b0;
    q.push_back('{32'h11, 32'h22, 5'd11, 1'b0});
    issue(5'd5, 5'd6, 5'd11, 1'b0);
    step();
    chk_ex("t5");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_hold_v", 64'(ex_valid),    64'd1);
      chk("t5_hold_d", 64'(ex_rs1_data), 64'h11);
      chk("t5_hold_r", 64'(id_ready),    64'd0);
    end
    ex_ready = 1'b1;
    step();
    chk("t5_rel_v", 64'(ex_valid), 64'd0);
    chk("t5_rel_r", 64'(id_ready), 64'd1);

    // flush in HOLD releases busy[ex_rd]
    ex_ready = 1'b0;
    q.push_back('{32'h22, 32'h22, 5'd4, 1'b1});
    issue(5'd6, 5'd6, 5'd4, 1'b1);
    step();
    chk_ex("t6");
    chk("t6_busy4_set", 64'(dut.busy_q[4]), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_fl_v",     64'(ex_valid),       64'd0);
    chk("t6_busy4_cl", 64'(dut.busy_q[4]),  64'd0);
    chk("t6_fl_r",     64'(id_ready),       64'd1);
    ex_ready = 1'b1;

    // flush in IDLE suppresses the handshake
    flush = 1'b1;
    issue(5'd5, 5'd5, 5'd3, 1'b1);
    flush = 1'b0;
    chk("t7_idle_r", 64'(id_ready), 64'd1);
    step();
    chk("t7_idle_v", 64'(ex_valid), 64'd0);

    // flush in READ: back to IDLE, busy untouched
    q.push_back('{32'h0, 32'h0, 5'd12, 1'b1});
    issue(5'd0, 5'd0, 5'd12, 1'b1);
    step();
    chk_ex("t8a");
    step();
    issue(5'd12, 5'd0, 5'd13, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t8_fl_r",    64'(id_ready),     64'd1);
    chk("t8_busy",    64'(dut.busy_q),   64'h1000);

    // reset while stalled in READ
    issue(5'd12, 5'd0, 5'd13, 1'b1);
    step();
    chk("t9_stall", 64'(ex_valid), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t9_busy", 64'(dut.busy_q), 64'd0);
    chk("t9_rdy",  64'(id_ready),   64'd1);
    chk("t9_v",    64'(ex_valid),   64'd0);

    chk("q_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
